inc_counter: RTL and testbench
==============================

Name: inc_counter

Overview:
- Parametrised registered successor to the 16-bit combinational incrementer.
- Holds a WIDTH-bit count and, when enabled, steps it up or down by a programmable amount each clock.
- Provides parallel load, a one-cycle carry/borrow pulse on wrap-around, and a sticky overflow flag.
- Used as a program-counter / address-generator primitive in the datapath.

Parameters:
- WIDTH, 16, count and step width in bits (minimum 2).
- RESET_VAL, 0, count value after reset (WIDTH bits).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value taken by load.
- dir  input  1  0 = up (add step), 1 = down (subtract step).
- step  input  WIDTH  increment magnitude, unsigned.
- ovf_clr  input  1  clears sticky overflow flag.
- sat  input  1  saturate instead of wrap (present only with COUNT_SAT_EN).
- count  output  WIDTH  registered count value.
- cout  output  1  registered one-cycle pulse: carry (up) or borrow (down) out of the MSB.
- ovf  output  1  sticky flag, set by any cout event.
- tc  output  1  combinational terminal count: count == all-ones when dir=0, count == 0 when dir=1.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: count = RESET_VAL, cout = 0, ovf = 0. rst has priority over every other input.
- Priority per edge: rst > load > en. With none asserted, count holds and cout = 0.
- Load:
  - count <= load_val; cout <= 0.
  - ovf unaffected, except that ovf_clr still applies.
  - en and dir are ignored that cycle.
- Enabled count: compute a WIDTH+1-bit result.
  - Up: {c, n} = count + step.
  - Down: {b, n} = count - step, where b = 1 when step > count.
  - count <= n (modulo 2^WIDTH); cout <= c or b.
- Latency: count reflects a load or step on the cycle after the edge that sampled it. cout is aligned with the new count value.
- step = 0 with en = 1: count holds, cout = 0.
- Wrap-around examples (WIDTH=16):
  - Up: 0xFFFF + 1 -> 0x0000 with cout = 1.
  - Down: 0x0000 - 1 -> 0xFFFF with cout = 1.
- ovf:
  - Set on any edge where cout is registered as 1.
  - Cleared by ovf_clr.
  - If set and clear coincide, set wins (the event is not lost).
- cout is a pulse: it deasserts on the next edge unless another wrap occurs. Back-to-back wraps keep it high.
- tc is purely combinational from count and dir, with no dependency on en.
- Reset mid-operation: any pending result is discarded and the reset values apply on that edge.
- Simultaneous load and en: the load wins and no cout is generated.

Optional Feature:
- Macro: COUNT_SAT_EN.
- Defined:
  - The sat port exists.
  - With sat = 1, an up-overflow clamps count to all-ones and a down-underflow clamps it to 0.
  - cout still pulses and ovf still sets on the clamping edge.
  - Further steps at the rail keep count clamped and pulse cout each enabled cycle with step != 0.
  - With sat = 0, behaviour is as for wrap.
- Undefined: the sat port is absent and arithmetic always wraps.

Test Plan:
- Reset: WIDTH=16, RESET_VAL=0x1234, rst high for one edge -> count = 0x1234, cout = 0, ovf = 0.
- Up wrap: load 0xFFFE, en = 1, dir = 0, step = 1 -> counts 0xFFFF then 0x0000; cout = 1 only on the 0x0000 cycle; ovf = 1 and stays 1.
- Down borrow: load 0x0003, dir = 1, step = 5 -> count 0xFFFE, cout = 1, tc = 0. Then ovf_clr with no wrap -> ovf = 0.
- Priority: load = 1, load_val = 0x00AA, en = 1, step = 3 on the same edge -> count = 0x00AA, cout = 0. Next edge with load = 0 -> count = 0x00AD.
- Sticky race: ovf_clr = 1 on the same edge as a wrap -> ovf = 1. With rst = 1 and en = 1 together -> count = RESET_VAL, ovf = 0.
- COUNT_SAT_EN: sat = 1, load 0xFFF0, step = 0x20, dir = 0 -> count 0xFFFF, cout = 1. Repeat step -> count stays 0xFFFF.

Source files
------------

// File: rtl/inc_counter.sv
// Registered up/down counter with programmable step, load, carry pulse and sticky overflow; COUNT_SAT_EN adds saturation.
// Latency: one clock from sampled load/step to count/cout; no backpressure, state advances every enabled edge.
module inc_counter #(
   parameter int unsigned            WIDTH     = 16,
   parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic [WIDTH-1:0] step,
   input  logic             ovf_clr,
`ifdef COUNT_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] count,
   output logic             cout,
   output logic             ovf,
   output logic             tc
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   res;
   logic             wrap;
   logic [WIDTH-1:0] step_val;

   // The extra MSB of the WIDTH+1-bit result is carry for add and borrow for subtract.
   assign sum  = {1'b0, count} + {1'b0, step};
   assign diff = {1'b0, count} - {1'b0, step};
   assign res  = dir ? diff : sum;
   assign wrap = res[WIDTH];

   always_comb begin
      step_val = res[WIDTH-1:0];
`ifdef COUNT_SAT_EN
      if (sat && wrap)
         step_val = dir ? '0 : '1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= RESET_VAL;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (load) begin
         count <= load_val;
         cout  <= 1'b0;
         ovf   <= ovf & ~ovf_clr;
      end else if (en) begin
         count <= step_val;
         cout  <= wrap;
         // A wrap on the same edge as a clear must not be lost.
         ovf   <= (ovf & ~ovf_clr) | wrap;
      end else begin
         cout  <= 1'b0;
         ovf   <= ovf & ~ovf_clr;
      end
   end

   assign tc = dir ? (count == '0) : (count == '1);

endmodule

// File: tb/tb_inc_counter.sv
// Scoreboard bench for inc_counter (WIDTH=16, RESET_VAL=0x1234); define COUNT_SAT_EN to cover saturation.
module tb_inc_counter;

   localparam logic [15:0] RV = 16'h1234;

   logic        clk = 1'b0;
   logic        rst, en, load, dir, ovf_clr, sat;
   logic [15:0] load_val, step;
   logic [15:0] count;
   logic        cout, ovf, tc;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] cnt;
      logic        co;
      logic        ov;
      logic        tc;
   } exp_t;

   exp_t exp_q[$];

   logic [15:0] m_count;
   logic        m_ovf;

   always #5 clk = ~clk;

   inc_counter #(.WIDTH(16), .RESET_VAL(RV)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .dir      (dir),
      .step     (step),
      .ovf_clr  (ovf_clr),
`ifdef COUNT_SAT_EN
      .sat      (sat),
`endif
      .count    (count),
      .cout     (cout),
      .ovf      (ovf),
      .tc       (tc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   // Drive one edge of stimulus, predict its result, then compare once the DUT has registered it.
   task automatic cyc(input string tag, input logic r, input logic ld, input logic [15:0] lv,
                      input logic e, input logic d, input logic [15:0] st,
                      input logic oc, input logic s);
      exp_t  x;
      int    tmp;
      logic  w;
      logic [15:0] n;
      rst = r; load = ld; load_val = lv; en = e; dir = d; step = st; ovf_clr = oc; sat = s;
      x.co = 1'b0;
      if (r) begin
         m_count = RV; m_ovf = 1'b0;
      end else if (ld) begin
         m_count = lv; m_ovf = m_ovf && !oc;
      end else if (e) begin
         if (!d) begin
            tmp = int'(m_count) + int'(st);
            w   = tmp > 65535;
            n   = tmp[15:0];
         end else begin
            w   = st > m_count;
            tmp = int'(m_count) - int'(st);
            n   = tmp[15:0];
         end
`ifdef COUNT_SAT_EN
         if (s && w) n = d ? 16'h0000 : 16'hFFFF;
`endif
         m_count = n;
         x.co    = w;
         m_ovf   = (m_ovf && !oc) || w;
      end else begin
         m_ovf = m_ovf && !oc;
      end
      x.cnt = m_count;
      x.ov  = m_ovf;
      x.tc  = d ? (m_count == 16'h0000) : (m_count == 16'hFFFF);
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_empty"}, 32'd0, 32'd1);
      end else begin
         x = exp_q.pop_front();
         chk({tag, "_count"}, {16'h0, count}, {16'h0, x.cnt});
         chk({tag, "_cout"},  {31'h0, cout},  {31'h0, x.co});
         chk({tag, "_ovf"},   {31'h0, ovf},   {31'h0, x.ov});
         chk({tag, "_tc"},    {31'h0, tc},    {31'h0, x.tc});
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b0; ovf_clr = 1'b0; sat = 1'b0;
      load_val = '0; step = '0;
      m_count = RV; m_ovf = 1'b0;
      @(negedge clk);

      cyc("reset",  1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
      chk("reset_val", {16'h0, count}, 32'h0000_1234);

      cyc("ld_fffe", 0, 1, 16'hFFFE, 0, 0, 16'h0000, 0, 0);
      cyc("up1",     0, 0, 16'h0000, 1, 0, 16'h0001, 0, 0);
      chk("up1_tc",  {31'h0, tc}, 32'd1);
      cyc("up_wrap", 0, 0, 16'h0000, 1, 0, 16'h0001, 0, 0);
      chk("up_wrap_cout", {31'h0, cout}, 32'd1);
      cyc("step0",   0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
      cyc("idle",    0, 0, 16'h0000, 0, 0, 16'h0001, 0, 0);

      cyc("ld_3",    0, 1, 16'h0003, 0, 1, 16'h0000, 0, 0);
      cyc("borrow",  0, 0, 16'h0000, 1, 1, 16'h0005, 0, 0);
      chk("borrow_val", {16'h0, count}, 32'h0000_FFFE);
      cyc("ovf_clr", 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 0);

      cyc("prio",    0, 1, 16'h00AA, 1, 0, 16'h0003, 0, 0);
      cyc("prio_nx", 0, 0, 16'h0000, 1, 0, 16'h0003, 0, 0);
      chk("prio_ad", {16'h0, count}, 32'h0000_00AD);

      cyc("ld_ffff", 0, 1, 16'hFFFF, 0, 0, 16'h0000, 0, 0);
      cyc("race",    0, 0, 16'h0000, 1, 0, 16'h0001, 1, 0);
      chk("race_ovf", {31'h0, ovf}, 32'd1);
      cyc("rst_en",  1, 0, 16'h0000, 1, 0, 16'h0001, 0, 0);

      cyc("ld_8000", 0, 1, 16'h8000, 0, 0, 16'h0000, 0, 0);
      cyc("b2b_1",   0, 0, 16'h0000, 1, 0, 16'hC000, 0, 0);
      cyc("b2b_2",   0, 0, 16'h0000, 1, 0, 16'hC000, 0, 0);
      cyc("b2b_3",   0, 0, 16'h0000, 0, 0, 16'hC000, 0, 0);

      cyc("ld_1",    0, 1, 16'h0001, 0, 1, 16'h0000, 0, 0);
      cyc("dn_zero", 0, 0, 16'h0000, 1, 1, 16'h0001, 0, 0);

      for (int i = 0; i < 60; i++) begin
         cyc("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0), 16'($urandom),
             ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 4)),
             ($urandom_range(0, 5) == 0), 1'b0);
      end

`ifdef COUNT_SAT_EN
      cyc("sat_ld",  0, 1, 16'hFFF0, 0, 0, 16'h0000, 1, 1);
      cyc("sat_up",  0, 0, 16'h0000, 1, 0, 16'h0020, 0, 1);
      chk("sat_up_val", {16'h0, count}, 32'h0000_FFFF);
      cyc("sat_rep", 0, 0, 16'h0000, 1, 0, 16'h0020, 0, 1);
      cyc("sat_ld2", 0, 1, 16'h0004, 0, 1, 16'h0000, 0, 1);
      cyc("sat_dn",  0, 0, 16'h0000, 1, 1, 16'h0010, 0, 1);
      chk("sat_dn_val", {16'h0, count}, 32'h0000_0000);
      cyc("sat_off", 0, 0, 16'h0000, 1, 1, 16'h0001, 0, 0);
      for (int i = 0; i < 40; i++) begin
         cyc("sat_rand", 1'b0, ($urandom_range(0, 7) == 0), 16'($urandom), 1'b1, 1'($urandom),
             16'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom));
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
